// File: rtl/o_fab_pipe.sv
// o_fab_pipe: registered fabric-to-periphery buffer with valid/ready flow control
//
// Carries a WIDTH-bit bus through STAGES register slices. An empty slice always
// accepts from the slice upstream, so bubbles collapse, and full throughput is
// kept while the periphery is ready.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   I          fabric-side data
//   I_VALID    fabric data valid
//   I_READY    buffer can accept I this cycle (combinational)
//   O          periphery-side data (last slice register)
//   O_VALID    O holds valid data (last slice valid register)
//   O_READY    periphery accepts O this cycle
//   OCCUPANCY  number of valid slices (registered)
module o_fab_pipe #(
    parameter int               WIDTH      = 8,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [WIDTH-1:0]             I,
    input  logic                         I_VALID,
    output logic                         I_READY,
    output logic [WIDTH-1:0]             O,
    output logic                         O_VALID,
    input  logic                         O_READY,
    output logic [$clog2(STAGES+1)-1:0]  OCCUPANCY
);

    localparam int OW = $clog2(STAGES+1);

    logic [WIDTH-1:0]  data [STAGES];
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [OW-1:0]     occ;
    logic              in_xfer;
    logic              out_xfer;

    if (STAGES < 1 || STAGES > 4 || WIDTH < 1 || WIDTH > 64) begin : g_bad_params
        $error("o_fab_pipe: STAGES must be 1..4 and WIDTH 1..64");
    end

    // A slice advances when it or any slice downstream of it is empty, or the
    // periphery is taking the output word. Written in unrolled form so the
    // ready chain has no self-referencing vector.
    for (genvar g = 0; g < STAGES; g++) begin : g_adv
        assign adv[g] = O_READY || !(&v[STAGES-1:g]);
    end

    assign I_READY   = adv[0];
    assign O         = data[STAGES-1];
    assign O_VALID   = v[STAGES-1];
    assign OCCUPANCY = occ;
    assign in_xfer   = I_VALID & I_READY;
    assign out_xfer  = O_VALID & O_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            v   <= '0;
            occ <= '0;
            for (int k = 0; k < STAGES; k++) data[k] <= INIT_VALUE;
        end else begin
            // Slice 0 captures I even when I_VALID is low; O must be qualified by O_VALID.
            if (adv[0]) begin
                data[0] <= I;
                v[0]    <= I_VALID;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    data[k] <= data[k-1];
                    v[k]    <= v[k-1];
                end
            end
            occ <= occ + OW'(in_xfer) - OW'(out_xfer);
        end
    end

endmodule
